// File: rtl/try_unit.sv
// Registered 6-bit bit-manipulation unit: one op per enabled edge, result on C.
// Optional macro TRY_UNIT_PARITY_EN adds a registered even-parity output par.
module try_unit #(
    parameter int WIDTH = 6
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] A,
    output logic [WIDTH-1:0] C,
    output logic             valid
`ifdef TRY_UNIT_PARITY_EN
    ,
    output logic             par
`endif
);

    localparam logic [2:0] OP_PASS = 3'b000;
    localparam logic [2:0] OP_REV  = 3'b001;
    localparam logic [2:0] OP_POP  = 3'b010;
    localparam logic [2:0] OP_CLZ  = 3'b011;
    localparam logic [2:0] OP_GRAY = 3'b100;
    localparam logic [2:0] OP_NEG  = 3'b101;
    localparam logic [2:0] OP_ROTL = 3'b110;
    localparam logic [2:0] OP_NOT  = 3'b111;

    localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

    logic [WIDTH-1:0] c_q, c_d;
    logic             valid_q, valid_d;
    logic [WIDTH-1:0] rev, pop, clz, res;

    always_comb begin
        rev = '0;
        pop = '0;
        clz = WIDTH'(WIDTH);
        for (int i = 0; i < WIDTH; i++) begin
            rev[i] = A[WIDTH-1-i];
            pop    = pop + WIDTH'(A[i]);
            // Ascending scan: the highest set bit is the last to win.
            if (A[i]) clz = WIDTH'(WIDTH - 1 - i);
        end
    end

    always_comb begin
        res = A;
        unique case (op)
            OP_PASS: res = A;
            OP_REV:  res = rev;
            OP_POP:  res = pop;
            OP_CLZ:  res = clz;
            OP_GRAY: res = A ^ (A >> 1);
            OP_NEG:  res = (~A) + ONE;
            OP_ROTL: res = {A[WIDTH-2:0], A[WIDTH-1]};
            OP_NOT:  res = ~A;
            default: res = A;
        endcase
    end

    always_comb begin
        c_d     = c_q;
        valid_d = valid_q;
        if (en) begin
            c_d     = res;
            valid_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            c_q     <= '0;
            valid_q <= 1'b0;
        end else begin
            c_q     <= c_d;
            valid_q <= valid_d;
        end
    end

    assign C     = c_q;
    assign valid = valid_q;

`ifdef TRY_UNIT_PARITY_EN
    logic par_q, par_d;

    always_comb begin
        par_d = par_q;
        if (en) par_d = ^res;
    end

    always_ff @(posedge clk) begin
        if (reset) par_q <= 1'b0;
        else       par_q <= par_d;
    end

    assign par = par_q;
`endif

endmodule

// File: tb/tb_try_unit.sv
// Self-checking bench for try_unit: directed sweeps, boundaries, hold,
// mid-stream reset and randomized traffic against an arithmetic model.
module tb_try_unit;

    logic       clk = 1'b0;
    logic       reset;
    logic       en;
    logic [2:0] op;
    logic [5:0] A;
    logic [5:0] C;
    logic       valid;
`ifdef TRY_UNIT_PARITY_EN
    logic       par;
`endif

    int checks   = 0;
    int failures = 0;

    logic [5:0] exp_c = '0;
    logic       exp_v = 1'b0;
    logic       exp_p = 1'b0;

    try_unit #(.WIDTH(6)) dut (
        .clk   (clk),
        .reset (reset),
        .en    (en),
        .op    (op),
        .A     (A),
        .C     (C),
        .valid (valid)
`ifdef TRY_UNIT_PARITY_EN
        ,
        .par   (par)
`endif
    );

    always #5 clk = ~clk;

    localparam logic [5:0] T21 [8] = '{
        6'b010101, 6'b101010, 6'b000011, 6'b000001,
        6'b011111, 6'b101011, 6'b101010, 6'b101010
    };
    localparam logic [5:0] T01 [8] = '{
        6'b000001, 6'b100000, 6'b000001, 6'b000101,
        6'b000001, 6'b111111, 6'b000010, 6'b111110
    };

    // Reference computed from the operation table with plain integer arithmetic.
    function automatic logic [5:0] ref_f(input int o, input int a);
        int r;
        int t;
        r = 0;
        case (o)
            0: r = a;
            1: for (int i = 0; i < 6; i++)
                   if (((a >> i) & 1) == 1) r += 1 << (5 - i);
            2: for (int i = 0; i < 6; i++) r += (a >> i) & 1;
            3: begin
                r = 6;
                t = a;
                while (t > 0) begin
                    r--;
                    t = t / 2;
                end
            end
            4: r = a ^ (a / 2);
            5: r = (64 - a) % 64;
            6: r = (a * 2) % 64 + a / 32;
            default: r = 63 - a;
        endcase
        return 6'(r);
    endfunction

    function automatic logic parity_of(input int v);
        int n;
        n = 0;
        for (int i = 0; i < 6; i++) n += (v >> i) & 1;
        return (n % 2) == 1;
    endfunction

    // Drive one cycle, then advance the model to what the edge should produce.
    task automatic cycle(input logic r, input logic e,
                         input logic [2:0] o, input logic [5:0] a);
        reset = r;
        en    = e;
        op    = o;
        A     = a;
        @(posedge clk);
        #1;
        if (r) begin
            exp_c = '0;
            exp_v = 1'b0;
            exp_p = 1'b0;
        end else if (e) begin
            exp_c = ref_f(int'(o), int'(a));
            exp_v = 1'b1;
            exp_p = parity_of(int'(exp_c));
        end
    endtask

    task automatic test_reset();
        cycle(1'b1, 1'b1, 3'd0, 6'b111111);
        cycle(1'b1, 1'b1, 3'd0, 6'b111111);
        checks++;
        if (C !== 6'b000000) begin
            failures++;
            $display("FAIL reset_C got=%b want=000000", C);
        end
        checks++;
        if (valid !== 1'b0) begin
            failures++;
            $display("FAIL reset_valid got=%b want=0", valid);
        end
        cycle(1'b0, 1'b0, 3'd0, 6'b111111);
        checks++;
        if (C !== 6'b000000 || valid !== 1'b0) begin
            failures++;
            $display("FAIL reset_release got=%b/%b want=000000/0", C, valid);
        end
    endtask

    task automatic test_sweep();
        for (int o = 0; o < 8; o++) begin
            cycle(1'b0, 1'b1, 3'(o), 6'b010101);
            checks++;
            if (C !== T21[o] || valid !== 1'b1) begin
                failures++;
                $display("FAIL sweep21_op%0d got=%b/%b want=%b/1",
                         o, C, valid, T21[o]);
            end
        end
        for (int o = 0; o < 8; o++) begin
            cycle(1'b0, 1'b1, 3'(o), 6'b000001);
            checks++;
            if (C !== T01[o] || valid !== 1'b1) begin
                failures++;
                $display("FAIL sweep01_op%0d got=%b/%b want=%b/1",
                         o, C, valid, T01[o]);
            end
        end
    endtask

    task automatic test_boundaries();
        logic [2:0] bo [5] = '{3'd3, 3'd5, 3'd2, 3'd5, 3'd6};
        logic [5:0] ba [5] = '{6'd0, 6'd0, 6'd0, 6'b100000, 6'b100000};
        logic [5:0] be [5] = '{6'b000110, 6'b000000, 6'b000000,
                               6'b100000, 6'b000001};
        for (int i = 0; i < 5; i++) begin
            cycle(1'b0, 1'b1, bo[i], ba[i]);
            checks++;
            if (C !== be[i]) begin
                failures++;
                $display("FAIL boundary%0d op=%0d A=%b got=%b want=%b",
                         i, bo[i], ba[i], C, be[i]);
            end
        end
    endtask

    task automatic test_hold();
        cycle(1'b0, 1'b1, 3'd0, 6'd21);
        for (int i = 0; i < 3; i++) begin
            cycle(1'b0, 1'b0, 3'd0, 6'd1);
            checks++;
            if (C !== 6'b010101 || valid !== 1'b1) begin
                failures++;
                $display("FAIL hold%0d got=%b/%b want=010101/1", i, C, valid);
            end
        end
        cycle(1'b1, 1'b1, 3'd0, 6'd1);
        checks++;
        if (C !== 6'b000000 || valid !== 1'b0) begin
            failures++;
            $display("FAIL midreset got=%b/%b want=000000/0", C, valid);
        end
        cycle(1'b0, 1'b1, 3'd1, 6'd1);
        checks++;
        if (C !== 6'b100000 || valid !== 1'b1) begin
            failures++;
            $display("FAIL reload got=%b/%b want=100000/1", C, valid);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 300; i++) begin
            cycle($urandom_range(0, 9) == 0, 1'($urandom),
                  3'($urandom), 6'($urandom));
            checks++;
            if (C !== exp_c || valid !== exp_v) begin
                failures++;
                $display("FAIL random%0d got=%b/%b want=%b/%b",
                         i, C, valid, exp_c, exp_v);
            end
`ifdef TRY_UNIT_PARITY_EN
            checks++;
            if (par !== exp_p) begin
                failures++;
                $display("FAIL random_par%0d got=%b want=%b", i, par, exp_p);
            end
`endif
        end
    endtask

`ifdef TRY_UNIT_PARITY_EN
    task automatic test_parity();
        cycle(1'b0, 1'b1, 3'd0, 6'b010101);
        checks++;
        if (par !== 1'b1) begin
            failures++;
            $display("FAIL par_21 got=%b want=1", par);
        end
        cycle(1'b0, 1'b1, 3'd0, 6'b000011);
        checks++;
        if (par !== 1'b0) begin
            failures++;
            $display("FAIL par_03 got=%b want=0", par);
        end
        cycle(1'b0, 1'b1, 3'd0, 6'b000111);
        cycle(1'b0, 1'b0, 3'd0, 6'b000000);
        checks++;
        if (par !== 1'b1) begin
            failures++;
            $display("FAIL par_hold got=%b want=1", par);
        end
        cycle(1'b1, 1'b1, 3'd0, 6'b000111);
        checks++;
        if (par !== 1'b0) begin
            failures++;
            $display("FAIL par_reset got=%b want=0", par);
        end
    endtask
`endif

    initial begin
        reset = 1'b1;
        en    = 1'b0;
        op    = 3'd0;
        A     = 6'd0;
        #2;
        test_reset();
        test_sweep();
        test_boundaries();
        test_hold();
`ifdef TRY_UNIT_PARITY_EN
        test_parity();
`endif
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/try_unit.md
Name: try_unit

Overview:
- Registered 6-bit bit-manipulation unit, used as a small utility and bring-up block beside the P4 single-cycle datapath, for example on opcode/funct fields.
- Takes a 6-bit operand A and an operation select.
- Produces a 6-bit result C one clock after capture.
- Pure datapath: no handshake beyond a load enable and a valid flag.

Parameters:
- WIDTH, 6, operand/result width. Only 6 is required to be supported; all values below assume 6.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- en  input  1  load enable; when 1, A/op are processed this cycle.
- op  input  3  operation select (encoding below).
- A  input  6  operand.
- C  output  6  registered result.
- valid  output  1  1 when C holds a result computed from a captured operand.

Behaviour:
- Reset, synchronous, active-high: on a rising edge with reset=1, C<=6'b000000 and valid<=0. Reset has priority over en.
- Load: on a rising edge with reset=0 and en=1, C<=f(op,A) and valid<=1. Latency is 1 cycle: the result is visible after the edge that samples A.
- Hold: with en=0 and reset=0, C and valid keep their values.
- Operation table, all results 6 bits, unsigned unless noted:
  - 000 PASS: C=A.
  - 001 REV: bit-reverse, C[i]=A[5-i].
  - 010 POPCNT: number of 1 bits in A, zero-extended (range 0..6).
  - 011 CLZ: count of leading zeros from bit 5 downward. A=0 gives 6.
  - 100 GRAY: C = A ^ (A>>1).
  - 101 NEG: two's complement, C = (~A+1) mod 64. A=0 gives 0; A=6'b100000 gives 6'b100000.
  - 110 ROTL: rotate left by 1, C={A[4:0],A[5]}.
  - 111 NOT: C=~A.
- No X propagation from op: all 8 encodings are defined.
- Reset asserted mid-stream clears C and valid on that edge. The next en=1 edge loads normally.

Optional Feature:
- Macro: TRY_UNIT_PARITY_EN.
- Defined:
  - Adds output port par (1 bit), registered alongside C.
  - par = XOR of the 6 bits of the value loaded into C (even-parity bit).
  - Reset value 0; holds when en=0.
- Undefined: the par port and its logic are absent; all other behaviour is unchanged.

Test Plan:
- Reset: assert reset 2 cycles with en=1, A=6'b111111 -> C=000000, valid=0. Release reset, en=0 -> C stays 000000, valid stays 0.
- Sweep op with A=6'b010101, en=1, one op per cycle, checking the result one cycle later:
  - PASS 010101, REV 101010, POPCNT 000011, CLZ 000001
  - GRAY 011111, NEG 101011, ROTL 101010, NOT 101010
  - valid=1 throughout.
- Sweep op with A=6'b000001:
  - PASS 000001, REV 100000, POPCNT 000001, CLZ 000101
  - GRAY 000001, NEG 111111, ROTL 000010, NOT 111110
- Boundaries:
  - A=0: CLZ -> 000110, NEG -> 000000, POPCNT -> 000000.
  - A=6'b100000: NEG -> 100000, ROTL -> 000001.
- Hold: load A=21 with PASS, then en=0 while A changes to 1 for 3 cycles -> C stays 010101. Assert reset on the next edge with en=1 -> C=000000, valid=0.
- Parity with TRY_UNIT_PARITY_EN defined: PASS A=010101 -> par=1. PASS A=000011 -> par=0. Reset -> par=0.
